rr_arb_mux: RTL and testbench

Parametrised N-channel round-robin arbitrating multiplexer with a registered, valid/ready-handshaked output stage. Each cycle it selects one requesting input channel under a rotating priority, captures that channel's data into a single-entry output register, and presents it downstream with the index of the source channel. It generalises the combinational 3-way select used in the datapath to an arbitrary channel count with fairness, flow control and one-cycle registered latency, and is used wherever several producers share one consumer (e.g. writeback-port or memory-request sharing).

---
 rtl/rr_arb_mux.sv | 173 +++++++++++++++++
 tb/tb_rr_arb_mux.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbitrating multiplexer with a single
// registered, valid/ready-handshaked output stage.
// Optional feature macro: ARB_MUX_LOCK_EN. When it is defined, the in_last_i
// port exists and a multi-beat burst holds the grant until its last beat.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module rr_arb_mux #(
    parameter int WIDTH  = `DATA_WIDTH,
    parameter int NUM_CH = 3,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_CH-1:0]       in_valid_i,
    input  logic [NUM_CH*WIDTH-1:0] in_data_i,
`ifdef ARB_MUX_LOCK_EN
    input  logic [NUM_CH-1:0]       in_last_i,
`endif
    output logic [NUM_CH-1:0]       in_ready_o,
    output logic                    out_valid_o,
    output logic [WIDTH-1:0]        out_data_o,
    output logic [SEL_W-1:0]        out_sel_o,
    input  logic                    out_ready_i
);

    // Channel count and last index at the widths used by the scan arithmetic.
    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

    // Channel that follows c in round-robin order (wraps after the last one).
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
        logic [SEL_W-1:0] n;
        if (c == LAST_CH) begin
            n = '0;
        end else begin
            n = c + SEL_W'(1);
        end
        return n;
    endfunction

    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_data_q,  out_data_d;
    logic [SEL_W-1:0]        out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]        ptr_q,       ptr_d;
`ifdef ARB_MUX_LOCK_EN
    logic                    lock_vld_q,  lock_vld_d;
    logic [SEL_W-1:0]        lock_ch_q,   lock_ch_d;
`endif

    logic [WIDTH-1:0]        ch_data_s [NUM_CH];
    logic                    can_load_s;
    logic                    grant_vld_s;
    logic [SEL_W-1:0]        grant_idx_s;
    logic                    xfer_s;
    logic [NUM_CH-1:0]       in_ready_s;

    // Unpack the flat data bus into one word per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign ch_data_s[g] = in_data_i[g*WIDTH +: WIDTH];
    end

    // The output register may accept a new beat when empty or draining now;
    // nothing is accepted while reset is asserted.
    assign can_load_s = (!out_valid_q || out_ready_i) && !rst_i;

    // Arbitration: first requester at or after ptr, or the locked channel.
    always_comb begin : arb_comb
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] cand;
        logic             hit;
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        sum         = '0;
        cand        = '0;
        hit         = 1'b0;
`ifdef ARB_MUX_LOCK_EN
        if (lock_vld_q) begin
            // A locked burst owns the port even while its channel idles.
            grant_vld_s = in_valid_i[lock_ch_q];
            grant_idx_s = lock_ch_q;
        end else begin
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                sum         = {1'b0, ptr_q} + (SEL_W+1)'(i);
                sum         = (sum >= NUM_CH_W) ? (sum - NUM_CH_W) : sum;
                cand        = sum[SEL_W-1:0];
                hit         = in_valid_i[cand] && !grant_vld_s;
                grant_idx_s = hit ? cand : grant_idx_s;
                grant_vld_s = grant_vld_s || hit;
            end
`ifdef ARB_MUX_LOCK_EN
        end
`endif
    end

    // One-hot accept toward the winning channel; zero when nothing can move.
    always_comb begin
        in_ready_s = '0;
        if (grant_vld_s && can_load_s) begin
            in_ready_s[grant_idx_s] = 1'b1;
        end else begin
            in_ready_s = '0;
        end
    end

    assign xfer_s = grant_vld_s && can_load_s;

    // Next state of the output register, pointer and lock.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef ARB_MUX_LOCK_EN
        lock_vld_d  = lock_vld_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data_s[grant_idx_s];
            out_sel_d   = grant_idx_s;
`ifdef ARB_MUX_LOCK_EN
            if (!in_last_i[grant_idx_s]) begin
                // Mid-burst: hold the grant, keep the pointer where it is.
                lock_vld_d = 1'b1;
                lock_ch_d  = grant_idx_s;
                ptr_d      = ptr_q;
            end else begin
                lock_vld_d = 1'b0;
                ptr_d      = next_ch(grant_idx_s);
            end
`else
            ptr_d       = next_ch(grant_idx_s);
`endif
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any held beat immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef ARB_MUX_LOCK_EN
            lock_vld_q  <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef ARB_MUX_LOCK_EN
            lock_vld_q  <= lock_vld_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (NUM_CH=3, WIDTH=32): directed vector
// table, hand-written reset/rotation/lock sequences, then random traffic
// against a behavioural reference model.
module tb_rr_arb_mux;
    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
`ifdef ARB_MUX_LOCK_EN
    logic [N-1:0]   in_last;
`endif
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] dch [N];

    rr_arb_mux #(.WIDTH(W), .NUM_CH(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
`ifdef ARB_MUX_LOCK_EN
        .in_last_i   (in_last),
`endif
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_ready_i (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] v;
        logic         ordy;
        logic [N-1:0] rdy;
        logic         ov;
        int           sel;
    } vec_t;

    vec_t tbl [15];

    // Reference model state
    int       m_ptr;
    bit       m_ov;
    logic [W-1:0] m_data;
    int       m_sel;
    bit       m_lock;
    int       m_lock_ch;
    logic [N-1:0] pend;
    logic [N-1:0] plast;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic o, input logic [N-1:0] lst);
        in_valid  = v;
        out_ready = o;
        for (int c = 0; c < N; c++) in_data[c*W +: W] = dch[c];
`ifdef ARB_MUX_LOCK_EN
        in_last = lst;
`else
        if (lst != '0) begin end
`endif
    endtask

    // One cycle: drive, check accept, clock, check registered outputs.
    task automatic cyc(input string nm, input logic [N-1:0] v, input logic o,
                       input logic [N-1:0] lst, input logic [N-1:0] erdy,
                       input logic eov, input int esel);
        drive(v, o, lst);
        #1;
        chk({nm, "_rdy"}, 32'(in_ready), 32'(erdy));
        @(posedge clk);
        #1;
        chk({nm, "_ov"},   32'(out_valid), 32'(eov));
        chk({nm, "_sel"},  32'(out_sel), 32'(esel));
        chk({nm, "_data"}, out_data, dch[esel]);
    endtask

    function automatic vec_t mk(input logic [N-1:0] v, input logic o,
                                input logic [N-1:0] r, input logic ov, input int s);
        vec_t t;
        t.v = v; t.ordy = o; t.rdy = r; t.ov = ov; t.sel = s;
        return t;
    endfunction

    // Round-robin winner from the rules: scan from ptr, wrapping; -1 if none.
    function automatic int m_winner(input logic [N-1:0] v);
        int c;
        if (m_lock) return v[m_lock_ch] ? m_lock_ch : -1;
        for (int i = 0; i < N; i++) begin
            c = (m_ptr + i) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_cycle();
        int w;
        bit o, xfer;
        logic [N-1:0] erdy;
        for (int c = 0; c < N; c++) begin
            if (!pend[c] && $urandom_range(0, 1) == 1) begin
                pend[c]  = 1'b1;
                dch[c]   = $urandom;
                plast[c] = ($urandom_range(0, 2) != 0);
            end
        end
        o = ($urandom_range(0, 3) != 0);
        drive(pend, o, plast);
        #1;
        w = m_winner(pend);
        xfer = (w >= 0) && (!m_ov || o);
        erdy = '0;
        if (xfer) erdy[w] = 1'b1;
        chk("rnd_rdy", 32'(in_ready), 32'(erdy));
        @(posedge clk);
        if (xfer) begin
            m_ov = 1'b1; m_data = dch[w]; m_sel = w; pend[w] = 1'b0;
`ifdef ARB_MUX_LOCK_EN
            if (!plast[w]) begin
                m_lock = 1'b1; m_lock_ch = w;
            end else begin
                m_lock = 1'b0; m_ptr = (w + 1) % N;
            end
`else
            m_ptr = (w + 1) % N;
`endif
        end else if (o) begin
            m_ov = 1'b0;
        end
        #1;
        chk("rnd_ov", 32'(out_valid), 32'(m_ov));
        chk("rnd_sel", 32'(out_sel), 32'(m_sel));
        chk("rnd_data", out_data, m_data);
    endtask

    initial begin
        tbl[0]  = mk(3'b010, 1'b1, 3'b010, 1'b1, 1);
        tbl[1]  = mk(3'b111, 1'b1, 3'b100, 1'b1, 2);
        tbl[2]  = mk(3'b111, 1'b1, 3'b001, 1'b1, 0);
        tbl[3]  = mk(3'b111, 1'b1, 3'b010, 1'b1, 1);
        tbl[4]  = mk(3'b111, 1'b0, 3'b000, 1'b1, 1);
        tbl[5]  = mk(3'b111, 1'b0, 3'b000, 1'b1, 1);
        tbl[6]  = mk(3'b111, 1'b0, 3'b000, 1'b1, 1);
        tbl[7]  = mk(3'b111, 1'b0, 3'b000, 1'b1, 1);
        tbl[8]  = mk(3'b101, 1'b1, 3'b100, 1'b1, 2);
        tbl[9]  = mk(3'b101, 1'b1, 3'b001, 1'b1, 0);
        tbl[10] = mk(3'b000, 1'b1, 3'b000, 1'b0, 0);
        tbl[11] = mk(3'b000, 1'b0, 3'b000, 1'b0, 0);
        tbl[12] = mk(3'b100, 1'b0, 3'b100, 1'b1, 2);
        tbl[13] = mk(3'b001, 1'b0, 3'b000, 1'b1, 2);
        tbl[14] = mk(3'b001, 1'b1, 3'b001, 1'b1, 0);

        dch[0] = 32'h1111_0000;
        dch[1] = 32'hDEAD_BEEF;
        dch[2] = 32'h2222_0002;

        // Power-on reset
        rst = 1'b1;
        drive(3'b111, 1'b1, 3'b111);
        #3;
        chk("por_ov", 32'(out_valid), 32'd0);
        chk("por_data", out_data, 32'd0);
        chk("por_sel", 32'(out_sel), 32'd0);
        chk("por_rdy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            cyc($sformatf("tbl%0d", i), tbl[i].v, tbl[i].ordy, 3'b111,
                tbl[i].rdy, tbl[i].ov, tbl[i].sel);
        end

        // Hold a beat, then reset asynchronously mid-cycle
        cyc("hold", 3'b111, 1'b0, 3'b111, 3'b000, 1'b1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ov", 32'(out_valid), 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_sel", 32'(out_sel), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Rotation with all channels requesting
        for (int i = 0; i < 6; i++) begin
            cyc("rot", 3'b111, 1'b1, 3'b111, 3'(1 << (i % 3)), 1'b1, i % 3);
        end

`ifdef ARB_MUX_LOCK_EN
        // Ch0 burst of 3 beats with an idle cycle; ch1 waits throughout
        cyc("lk0", 3'b011, 1'b1, 3'b000, 3'b001, 1'b1, 0);
        cyc("lk1", 3'b011, 1'b1, 3'b000, 3'b001, 1'b1, 0);
        cyc("lkidle", 3'b010, 1'b1, 3'b000, 3'b000, 1'b0, 0);
        cyc("lk2", 3'b011, 1'b1, 3'b001, 3'b001, 1'b1, 0);
        cyc("lkrel", 3'b010, 1'b1, 3'b000, 3'b010, 1'b1, 1);
`endif

        // Random traffic against the model, from a fresh reset
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_ptr = 0; m_ov = 1'b0; m_data = '0; m_sel = 0;
        m_lock = 1'b0; m_lock_ch = 0;
        pend = '0; plast = '1;
        for (int i = 0; i < 300; i++) rand_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
